cache_mem_arbiter: RTL and testbench

- Shares the single downstream memory read/write port between the instruction-cache refill path and the data-cache refill/writeback path.
- Accepts one request at a time and grants round-robin on ties.
- Drives a level-held request to memory, returns the response to the granted requester as a one-cycle ok pulse, and aborts with an error if memory never answers.
- Sits between i_cache1 and the data cache on one side and the AXI4 bridge on the other.

---
 rtl/cache_mem_arbiter_if.sv | 38 +++
 rtl/cache_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and memory-bridge signals around cache_mem_arbiter.
// master: the arbiter itself; slave: the caches and bridge it serves.
interface cache_mem_arbiter_if;
    logic        i_req;
    logic [63:0] i_addr;
    logic [31:0] i_data;
    logic        i_ok;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wstrb;
    logic [63:0] d_rdata;
    logic        d_ok;
    logic        d_err;

    logic        mem_valid;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_rdata;
    logic        mem_ok;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ok,
        output i_data, i_ok, i_err, d_rdata, d_ok, d_err,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ok,
        input  i_data, i_ok, i_err, d_rdata, d_ok, d_err,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache refill and dcache refill/writeback.
// One transaction at a time, round-robin on ties, abort with error on timeout.
module cache_mem_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input logic                 clk,
    input logic                 rst,
    cache_mem_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             last_i;
    logic [CNT_W-1:0] cnt;
    logic             grant_i;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        grant_i = bus.i_req && (!bus.d_req || !last_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_i        <= 1'b0;
            cnt           <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            bus.i_ok      <= 1'b0;
            bus.i_err     <= 1'b0;
            bus.i_data    <= '0;
            bus.d_ok      <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        cnt           <= '0;
                        bus.mem_valid <= 1'b1;
                        if (grant_i) begin
                            state         <= BUSY_I;
                            last_i        <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.i_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_wstrb <= '0;
                        end else begin
                            state         <= BUSY_D;
                            last_i        <= 1'b0;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : 8'h00;
                        end
                    end
                end

                BUSY_I: begin
                    cnt <= cnt + 1'b1;
                    // mem_ok on the last allowed cycle still completes normally.
                    if (bus.mem_ok) begin
                        state         <= DONE_I;
                        bus.mem_valid <= 1'b0;
                        bus.i_ok      <= 1'b1;
                        bus.i_data    <= bus.mem_addr[2] ? bus.mem_rdata[63:32]
                                                         : bus.mem_rdata[31:0];
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE_I;
                        bus.mem_valid <= 1'b0;
                        bus.i_ok      <= 1'b1;
                        bus.i_err     <= 1'b1;
                        bus.i_data    <= '0;
                    end
                end

                BUSY_D: begin
                    cnt <= cnt + 1'b1;
                    if (bus.mem_ok) begin
                        state         <= DONE_D;
                        bus.mem_valid <= 1'b0;
                        bus.d_ok      <= 1'b1;
                        bus.d_rdata   <= bus.mem_rdata;
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE_D;
                        bus.mem_valid <= 1'b0;
                        bus.d_ok      <= 1'b1;
                        bus.d_err     <= 1'b1;
                        bus.d_rdata   <= '0;
                    end
                end

                DONE_I: begin
                    state     <= IDLE;
                    bus.i_ok  <= 1'b0;
                    bus.i_err <= 1'b0;
                end

                DONE_D: begin
                    state     <= IDLE;
                    bus.d_ok  <= 1'b0;
                    bus.d_err <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: the bench plays both caches and the memory bridge.
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(
        .TIMEOUT(8),
        .CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.mem_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.mem_valid) check({tag, "_wait_valid"}, bus.mem_valid, 1);
    endtask

    // Waits for the grant, checks the held memory request for lat cycles,
    // answers with mem_ok, then checks the ok pulse and drops the served request.
    task automatic run_txn(input string tag, input logic side_i, input logic [63:0] a,
                           input logic we, input logic [63:0] wd, input logic [7:0] ws,
                           input int lat, input logic [63:0] rd, input logic [63:0] exp_data);
        wait_valid(tag);
        for (int c = 0; c < lat; c++) begin
            check({tag, "_mem_valid"}, bus.mem_valid, 1);
            check({tag, "_mem_addr"},  bus.mem_addr, a);
            check({tag, "_mem_we"},    bus.mem_we, we);
            check({tag, "_mem_wdata"}, bus.mem_wdata, wd);
            check({tag, "_mem_wstrb"}, bus.mem_wstrb, ws);
            tick();
        end
        bus.mem_ok    = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ok    = 1'b0;
        bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        check({tag, "_i_ok"},      bus.i_ok, side_i);
        check({tag, "_d_ok"},      bus.d_ok, !side_i);
        check({tag, "_both_ok"},   bus.i_ok & bus.d_ok, 0);
        check({tag, "_done_valid"}, bus.mem_valid, 0);
        if (side_i) begin
            check({tag, "_i_err"},  bus.i_err, 0);
            check({tag, "_i_data"}, bus.i_data, exp_data);
            bus.i_req = 1'b0;
        end else begin
            check({tag, "_d_err"},   bus.d_err, 0);
            check({tag, "_d_rdata"}, bus.d_rdata, exp_data);
            bus.d_req = 1'b0;
        end
        tick();
        check({tag, "_i_ok_pulse"}, bus.i_ok, 0);
        check({tag, "_d_ok_pulse"}, bus.d_ok, 0);
    endtask

    initial begin
        int n;
        bus.i_req     = 1'b1;
        bus.i_addr    = 64'h8000_0000;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 64'h8000_2000;
        bus.d_wdata   = 64'h0;
        bus.d_wstrb   = 8'hFF;
        bus.mem_ok    = 1'b0;
        bus.mem_rdata = 64'h0;

        // Reset with both requests pending
        tick();
        tick();
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_we",    bus.mem_we, 0);
        check("rst_mem_addr",  bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_wstrb", bus.mem_wstrb, 0);
        check("rst_i_ok",      bus.i_ok, 0);
        check("rst_i_err",     bus.i_err, 0);
        check("rst_i_data",    bus.i_data, 0);
        check("rst_d_ok",      bus.d_ok, 0);
        check("rst_d_err",     bus.d_err, 0);
        check("rst_d_rdata",   bus.d_rdata, 0);
        rst = 1'b0;
        run_txn("first_i", 1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 1,
                64'hCAFE_F00D_1234_5678, 64'h1234_5678);
        run_txn("then_d", 1'b0, 64'h8000_2000, 1'b0, 64'h0, 8'h00, 1,
                64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708);

        // Icache read of the upper word
        bus.i_addr = 64'h8000_0004;
        bus.i_req  = 1'b1;
        run_txn("i_upper", 1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h00, 3,
                64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF);

        // Dcache write
        bus.d_we    = 1'b1;
        bus.d_addr  = 64'h8000_1000;
        bus.d_wdata = 64'h1122_3344_5566_7788;
        bus.d_wstrb = 8'h0F;
        bus.d_req   = 1'b1;
        run_txn("d_write", 1'b0, 64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 3,
                64'h0000_0000_0000_5555, 64'h0000_0000_0000_5555);
        check("i_data_hold", bus.i_data, 64'hDEAD_BEEF);

        // Continuous contention: last grant was D, so I, D, I, D
        bus.i_addr  = 64'h8000_3008;
        bus.d_addr  = 64'h8000_4000;
        bus.d_we    = 1'b0;
        bus.d_wdata = 64'h0;
        bus.d_wstrb = 8'h00;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        run_txn("cont0_i", 1'b1, 64'h8000_3008, 1'b0, 64'h0, 8'h00, 1,
                64'h1111_1111_2222_2222, 64'h2222_2222);
        bus.i_req = 1'b1;
        run_txn("cont1_d", 1'b0, 64'h8000_4000, 1'b0, 64'h0, 8'h00, 2,
                64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555);
        bus.d_req = 1'b1;
        run_txn("cont2_i", 1'b1, 64'h8000_3008, 1'b0, 64'h0, 8'h00, 1,
                64'h3333_3333_4444_4444, 64'h4444_4444);
        bus.i_req = 1'b1;
        run_txn("cont3_d", 1'b0, 64'h8000_4000, 1'b0, 64'h0, 8'h00, 1,
                64'h6666_6666_6666_6666, 64'h6666_6666_6666_6666);
        bus.i_req = 1'b0;
        tick();

        // Timeout: memory never answers
        bus.d_addr = 64'h8000_7000;
        bus.d_req  = 1'b1;
        wait_valid("tmo");
        n = 0;
        while (bus.mem_valid && n < 30) begin
            n++;
            tick();
        end
        check("tmo_valid_cycles", 64'(n), 8);
        check("tmo_d_ok",    bus.d_ok, 1);
        check("tmo_d_err",   bus.d_err, 1);
        check("tmo_d_rdata", bus.d_rdata, 0);
        bus.d_req = 1'b0;
        tick();
        check("tmo_d_ok_pulse",  bus.d_ok, 0);
        check("tmo_d_err_pulse", bus.d_err, 0);
        check("tmo_idle_valid",  bus.mem_valid, 0);

        // Reset during the second BUSY_D cycle
        bus.d_we    = 1'b1;
        bus.d_addr  = 64'h8000_5000;
        bus.d_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        bus.d_wstrb = 8'hF0;
        bus.d_req   = 1'b1;
        wait_valid("mrst");
        tick();
        check("mrst_busy2_valid", bus.mem_valid, 1);
        rst        = 1'b1;
        bus.i_req  = 1'b1;
        bus.i_addr = 64'h8000_6004;
        tick();
        check("mrst_valid", bus.mem_valid, 0);
        check("mrst_d_ok",  bus.d_ok, 0);
        check("mrst_d_err", bus.d_err, 0);
        rst           = 1'b0;
        bus.mem_ok    = 1'b1;
        bus.mem_rdata = 64'h9999_9999_9999_9999;
        tick();
        bus.mem_ok = 1'b0;
        check("mrst_stray_d_ok", bus.d_ok, 0);
        check("mrst_stray_i_ok", bus.i_ok, 0);
        check("mrst_grant_valid", bus.mem_valid, 1);
        check("mrst_grant_addr",  bus.mem_addr, 64'h8000_6004);
        bus.d_req = 1'b0;
        run_txn("mrst_i", 1'b1, 64'h8000_6004, 1'b0, 64'h0, 8'h00, 1,
                64'hABCD_EF01_2345_6789, 64'hABCD_EF01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
